// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller.
//   - stall_state_e : controller state encoding (also driven on the debug port)
//   - ifid_t        : 33-bit IF/ID register contents (instr, pc, valid)
//   - NOP_INSTR     : default bubble/flush encoding
package pipe_stall_ctrl_pkg;

  localparam logic [15:0] NOP_INSTR = 16'h0800;

  typedef enum logic [2:0] {
    ST_RUN        = 3'd0,
    ST_HZ_STALL   = 3'd1,
    ST_MEM_FREEZE = 3'd2,
    ST_DISCARD    = 3'd3,
    ST_HALTED     = 3'd4
  } stall_state_e;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
    logic        valid;
  } ifid_t;

endpackage

// File: rtl/pipe_stall_ctrl_ifid_reg.sv
// IF/ID pipeline register.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   we_i       : write enable; when 0 the register holds
//   nop_i      : with we_i, load the bubble (NOP_INSTR, pc 0, valid 0)
//   instr_i    : fetched instruction
//   pc_i       : PC+2 of the fetched instruction
//   q_o        : registered {instr, pc, valid}
module ifid_reg
  import pipe_stall_ctrl_pkg::*;
#(
  parameter logic [15:0] NOP_VAL = 16'h0800
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we_i,
  input  logic        nop_i,
  input  logic [15:0] instr_i,
  input  logic [15:0] pc_i,
  output ifid_t       q_o
);

  ifid_t q_q;
  ifid_t q_d;

  always_comb begin
    q_d = q_q;
    if (we_i) begin
      if (nop_i) begin
        q_d.instr = NOP_VAL;
        q_d.pc    = 16'h0000;
        q_d.valid = 1'b0;
      end else begin
        q_d.instr = instr_i;
        q_d.pc    = pc_i;
        q_d.valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q.instr <= NOP_VAL;
      q_q.pc    <= 16'h0000;
      q_q.valid <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall controller for the 5-stage 16-bit pipeline.
// Owns the IF/ID register, gates the PC and downstream pipeline-register
// write enables, and requests NOP bubbles into ID/EX.
//
// Optional feature: define PIPE_STALL_PERF_EN to build the saturating
// stall-cycle counter on stall_cnt; otherwise stall_cnt is tied to 0.
//
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   hz_en        : hazard unit enable, 0 = hold decode
//   imem_stall   : instruction fetch outstanding
//   imem_done    : fetch data valid this cycle
//   dmem_stall   : data memory busy, freezes the whole pipeline
//   flush        : taken branch/jump resolved in EX (held during a freeze)
//   halt_dec     : HALT decoded in ID
//   fetch_instr  : fetched instruction
//   fetch_pc     : PC+2 of the fetched instruction
//   pc_we        : PC write enable
//   ifid_instr   : IF/ID instruction to decode
//   ifid_pc      : IF/ID PC+2 to decode
//   ifid_valid   : IF/ID valid, 0 = bubble
//   idex_bubble  : ID/EX loads NOP / zero controls
//   pipe_we      : ID/EX, EX/MEM, MEM/WB write enable
//   stall_cnt    : stall cycle counter
//   dbg_state    : current controller state (stall_state_e encoding)
//
// Handshake: there is no valid/ready pair here; every enable is a pure
// combinational function of the current state and this cycle's inputs and
// takes effect on the next rising clk edge.
module pipe_stall_ctrl #(
  parameter logic [15:0] NOP_INSTR = pipe_stall_ctrl_pkg::NOP_INSTR,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hz_en,
  input  logic             imem_stall,
  input  logic             imem_done,
  input  logic             dmem_stall,
  input  logic             flush,
  input  logic             halt_dec,
  input  logic [15:0]      fetch_instr,
  input  logic [15:0]      fetch_pc,
  output logic             pc_we,
  output logic [15:0]      ifid_instr,
  output logic [15:0]      ifid_pc,
  output logic             ifid_valid,
  output logic             idex_bubble,
  output logic             pipe_we,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [2:0]       dbg_state
);

  import pipe_stall_ctrl_pkg::*;

  stall_state_e state_q, state_d;
  logic         ifid_we, ifid_nop;
  logic         fetch_wait;
  ifid_t        ifid_q;

  // A fetch is only outstanding if no data arrives this cycle.
  assign fetch_wait = imem_stall & ~imem_done;

  always_comb begin
    pc_we       = 1'b1;
    pipe_we     = 1'b1;
    idex_bubble = 1'b0;
    ifid_we     = 1'b1;
    ifid_nop    = 1'b0;
    state_d     = state_q;
    case (state_q)
      ST_HALTED: begin
        // PC frozen for good; downstream keeps draining unless memory blocks.
        pc_we = 1'b0;
        if (dmem_stall) begin
          pipe_we = 1'b0;
          ifid_we = 1'b0;
        end else begin
          ifid_nop = 1'b1;
        end
      end
      ST_DISCARD: begin
        if (dmem_stall) begin
          pc_we   = 1'b0;
          pipe_we = 1'b0;
          ifid_we = 1'b0;
        end else begin
          // Whatever arrives from the stale fetch is dropped.
          ifid_nop    = 1'b1;
          idex_bubble = flush | ~hz_en;
          if (imem_done) begin
            pc_we   = 1'b1;
            // A new redirect with a fresh outstanding fetch keeps discarding.
            state_d = (flush & imem_stall) ? ST_DISCARD : ST_RUN;
          end else begin
            pc_we = 1'b0;
          end
        end
      end
      default: begin
        if (dmem_stall) begin
          // Flush/hazard are deferred: their sources hold them until release.
          pc_we   = 1'b0;
          pipe_we = 1'b0;
          ifid_we = 1'b0;
          state_d = ST_MEM_FREEZE;
        end else if (flush) begin
          idex_bubble = 1'b1;
          ifid_nop    = 1'b1;
          if (fetch_wait) begin
            pc_we   = 1'b0;
            state_d = ST_DISCARD;
          end else begin
            pc_we   = 1'b1;
            state_d = ST_RUN;
          end
        end else if (!hz_en) begin
          pc_we       = 1'b0;
          ifid_we     = 1'b0;
          idex_bubble = 1'b1;
          state_d     = ST_HZ_STALL;
        end else if (halt_dec) begin
          pc_we    = 1'b0;
          ifid_nop = 1'b1;
          state_d  = ST_HALTED;
        end else if (fetch_wait) begin
          pc_we    = 1'b0;
          ifid_nop = 1'b1;
          state_d  = ST_RUN;
        end else begin
          state_d = ST_RUN;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  ifid_reg #(
    .NOP_VAL (NOP_INSTR)
  ) u_ifid_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .we_i    (ifid_we),
    .nop_i   (ifid_nop),
    .instr_i (fetch_instr),
    .pc_i    (fetch_pc),
    .q_o     (ifid_q)
  );

  assign ifid_instr = ifid_q.instr;
  assign ifid_pc    = ifid_q.pc;
  assign ifid_valid = ifid_q.valid;
  assign dbg_state  = state_q;

`ifdef PIPE_STALL_PERF_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Counts PC-stalled cycles; the permanent stall of HALTED is excluded.
  always_comb begin
    cnt_d = cnt_q;
    if (!pc_we && (state_q != ST_HALTED) && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stall_cnt = cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule
